// File: rtl/vedic_pkg.sv
// Shared sizing defaults, derived word counts and FSM state encoding for the Vedic256 operand stager.
package vedic_pkg;

   localparam int OP_W_DEF   = 256;
   localparam int WORD_W_DEF = 32;
   localparam int N_IN       = OP_W_DEF / WORD_W_DEF;
   localparam int N_OUT      = 2 * OP_W_DEF / WORD_W_DEF;
   localparam int CNT_W      = $clog2(N_OUT);

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      MUL,
      MUL_WAIT,
      DRAIN
   } stager_state_t;

endpackage

// File: rtl/vedic_word_mux.sv
// Combinational product-word select: picks word sel_i of the captured product and flags the final word.
module vedic_word_mux
   import vedic_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int N_WORDS = N_OUT,
   parameter int SEL_W   = CNT_W
)
(
   input  logic [N_WORDS*WORD_W-1:0] prod_i,
   input  logic [SEL_W-1:0]          sel_i,
   output logic [WORD_W-1:0]         word_o,
   output logic                      last_o
);

   always_comb begin
      word_o = '0;
      for (int i = 0; i < N_WORDS; i++) begin
         if (sel_i == SEL_W'(i)) begin
            word_o = prod_i[i*WORD_W +: WORD_W];
         end
      end
   end

   assign last_o = (sel_i == SEL_W'(N_WORDS - 1));

endmodule

// File: rtl/vedic256_operand_stager.sv
// Loads A then B word-serially, holds them on mul_a/mul_b, captures mul_p and drains it word-serially; no load/drain overlap.
// VEDIC_MUL_PIPE_EN inserts MUL_WAIT so the external multiplier gets two cycles before capture.
module vedic256_operand_stager
   import vedic_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int OP_W   = OP_W_DEF
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_data,
   output logic [OP_W-1:0]     mul_a,
   output logic [OP_W-1:0]     mul_b,
   input  logic [2*OP_W-1:0]   mul_p,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORD_W-1:0]   out_data,
   output logic                out_last,
   output logic                busy
);

   localparam int NI = OP_W / WORD_W;
   localparam int NO = 2 * OP_W / WORD_W;
   localparam int CW = $clog2(NO);

   stager_state_t        state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [OP_W-1:0]      a_q, a_d;
   logic [OP_W-1:0]      b_q, b_d;
   logic [2*OP_W-1:0]    prod_q, prod_d;
   logic                 loading;
   logic                 in_fire;
   logic                 out_fire;
   logic                 mux_last;
   logic [WORD_W-1:0]    mux_word;

   assign loading   = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign in_ready  = rst_n && loading;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = (state_q == DRAIN);
   assign out_fire  = out_valid && out_ready;
   assign out_last  = out_valid && mux_last;
   assign out_data  = mux_word;
   assign busy      = !((state_q == LOAD_A) && (cnt_q == '0));
   assign mul_a     = a_q;
   assign mul_b     = b_q;

   vedic_word_mux #(
      .WORD_W  (WORD_W),
      .N_WORDS (NO),
      .SEL_W   (CW)
   ) u_word_mux (
      .prod_i (prod_q),
      .sel_i  (cnt_q),
      .word_o (mux_word),
      .last_o (mux_last)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      case (state_q)
         LOAD_A, LOAD_B: begin
            if (in_fire) begin
               for (int i = 0; i < NI; i++) begin
                  if (cnt_q == CW'(i)) begin
                     if (state_q == LOAD_A) a_d[i*WORD_W +: WORD_W] = in_data;
                     else                   b_d[i*WORD_W +: WORD_W] = in_data;
                  end
               end
               if (cnt_q == CW'(NI - 1)) begin
                  cnt_d   = '0;
                  state_d = (state_q == LOAD_A) ? LOAD_B : MUL;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
`ifdef VEDIC_MUL_PIPE_EN
         // The multiplier path is constrained as two cycles, so capture one state later.
         MUL: state_d = MUL_WAIT;
         MUL_WAIT: begin
            prod_d  = mul_p;
            state_d = DRAIN;
         end
`else
         MUL: begin
            prod_d  = mul_p;
            state_d = DRAIN;
         end
`endif
         DRAIN: begin
            if (out_fire) begin
               if (mux_last) begin
                  cnt_d   = '0;
                  state_d = LOAD_A;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = LOAD_A;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LOAD_A;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
      end
   end

endmodule
